// File: rtl/execute_stage_if.sv
// Signal bundle between decode/forwarding sources and the execute stage,
// including the EX/MEM latched outputs and the combinational branch results.
interface execute_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          ihit;
  logic          flush;
  logic          bubble;
  logic [DW-1:0] rdat1;
  logic [DW-1:0] rdat2;
  logic [DW-1:0] imm;
  logic [4:0]    shamt;
  logic          ALUSrc;
  logic [3:0]    ALUOp;
  logic          ovfChk;
  logic          dREN;
  logic          dWEN;
  logic          regWr;
  logic [1:0]    regSel;
  logic [RW-1:0] regDst;
  logic [RW-1:0] rs;
  logic [RW-1:0] rt;
  logic [DW-1:0] nPC;
  logic          branch;
  logic          bne;
  logic          jr;
  logic          mem_regWr;
  logic [RW-1:0] mem_regDst;
  logic [DW-1:0] mem_ALUOut;
  logic          wb_regWr;
  logic [RW-1:0] wb_regDst;
  logic [DW-1:0] wb_wdat;

  logic          dREN_next;
  logic          dWEN_next;
  logic          regWr_next;
  logic          ovf_next;
  logic [1:0]    regSel_next;
  logic [RW-1:0] regDst_next;
  logic [DW-1:0] ALUOut_next;
  logic [DW-1:0] storeData_next;
  logic [DW-1:0] nPC_next;
  logic          branchTaken;
  logic [DW-1:0] branchTarget;
  logic [DW-1:0] jrTarget;

  modport master (
    output ihit, flush, bubble, rdat1, rdat2, imm, shamt, ALUSrc, ALUOp, ovfChk,
           dREN, dWEN, regWr, regSel, regDst, rs, rt, nPC, branch, bne, jr,
           mem_regWr, mem_regDst, mem_ALUOut, wb_regWr, wb_regDst, wb_wdat,
    input  dREN_next, dWEN_next, regWr_next, ovf_next, regSel_next, regDst_next,
           ALUOut_next, storeData_next, nPC_next, branchTaken, branchTarget, jrTarget
  );

  modport slave (
    input  ihit, flush, bubble, rdat1, rdat2, imm, shamt, ALUSrc, ALUOp, ovfChk,
           dREN, dWEN, regWr, regSel, regDst, rs, rt, nPC, branch, bne, jr,
           mem_regWr, mem_regDst, mem_ALUOut, wb_regWr, wb_regDst, wb_wdat,
    output dREN_next, dWEN_next, regWr_next, ovf_next, regSel_next, regDst_next,
           ALUOut_next, storeData_next, nPC_next, branchTaken, branchTarget, jrTarget
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch/jr resolution and the
// EX/MEM pipeline register feeding the memory stage.
module execute_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  execute_stage_if.slave   io_ex
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_NOR  = 4'h5,
    ALU_SLT  = 4'h6,
    ALU_SLTU = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_SRA  = 4'hA,
    ALU_LUI  = 4'hB
  } aluOp_e;

  typedef struct packed {
    logic          dREN;
    logic          dWEN;
    logic          regWr;
    logic          ovf;
    logic [1:0]    regSel;
    logic [RW-1:0] regDst;
    logic [DW-1:0] aluOut;
    logic [DW-1:0] storeData;
    logic [DW-1:0] nPC;
  } exMem_t;

  logic [DW-1:0] w_opA;
  logic [DW-1:0] w_fwdB;
  logic [DW-1:0] w_opB;
  logic [DW-1:0] w_sum;
  logic [DW-1:0] w_diff;
  logic [DW-1:0] w_aluOut;
  logic          w_ovf;
  logic          w_isAdd;
  logic          w_isSub;
  exMem_t        w_exMemNext;
  exMem_t        r_exMem;

  // Memory stage is younger than writeback, so its value wins; r0 is never forwarded.
  function automatic logic [DW-1:0] fwdSel(
    input logic [RW-1:0] src,
    input logic [DW-1:0] regVal,
    input logic          memWr,
    input logic [RW-1:0] memDst,
    input logic [DW-1:0] memVal,
    input logic          wbWr,
    input logic [RW-1:0] wbDst,
    input logic [DW-1:0] wbVal
  );
    logic [DW-1:0] sel;
    sel = regVal;
    if (memWr && (memDst != '0) && (memDst == src)) begin
      sel = memVal;
    end else if (wbWr && (wbDst != '0) && (wbDst == src)) begin
      sel = wbVal;
    end
    return sel;
  endfunction

  assign w_opA = fwdSel(io_ex.rs, io_ex.rdat1, io_ex.mem_regWr, io_ex.mem_regDst,
                        io_ex.mem_ALUOut, io_ex.wb_regWr, io_ex.wb_regDst, io_ex.wb_wdat);
  assign w_fwdB = fwdSel(io_ex.rt, io_ex.rdat2, io_ex.mem_regWr, io_ex.mem_regDst,
                         io_ex.mem_ALUOut, io_ex.wb_regWr, io_ex.wb_regDst, io_ex.wb_wdat);
  assign w_opB  = io_ex.ALUSrc ? io_ex.imm : w_fwdB;

  assign w_sum   = w_opA + w_opB;
  assign w_diff  = w_opA - w_opB;
  assign w_isAdd = (io_ex.ALUOp == ALU_ADD);
  assign w_isSub = (io_ex.ALUOp == ALU_SUB);

  always_comb begin
    w_aluOut = '0;
    unique case (io_ex.ALUOp)
      ALU_ADD:  w_aluOut = w_sum;
      ALU_SUB:  w_aluOut = w_diff;
      ALU_AND:  w_aluOut = w_opA & w_opB;
      ALU_OR:   w_aluOut = w_opA | w_opB;
      ALU_XOR:  w_aluOut = w_opA ^ w_opB;
      ALU_NOR:  w_aluOut = ~(w_opA | w_opB);
      ALU_SLT:  w_aluOut = {{(DW-1){1'b0}}, ($signed(w_opA) < $signed(w_opB))};
      ALU_SLTU: w_aluOut = {{(DW-1){1'b0}}, (w_opA < w_opB)};
      ALU_SLL:  w_aluOut = w_opB << io_ex.shamt;
      ALU_SRL:  w_aluOut = w_opB >> io_ex.shamt;
      ALU_SRA:  w_aluOut = $unsigned($signed(w_opB) >>> io_ex.shamt);
      ALU_LUI:  w_aluOut = {io_ex.imm[15:0], {(DW-16){1'b0}}};
      default:  w_aluOut = '0;
    endcase
  end

  // Overflow: same-signed add (or opposite-signed subtract) whose result flips sign.
  always_comb begin
    w_ovf = 1'b0;
    if (io_ex.ovfChk) begin
      if (w_isAdd) begin
        w_ovf = (w_opA[DW-1] == w_opB[DW-1]) && (w_sum[DW-1] != w_opA[DW-1]);
      end else if (w_isSub) begin
        w_ovf = (w_opA[DW-1] != w_opB[DW-1]) && (w_diff[DW-1] != w_opA[DW-1]);
      end
    end
  end

  assign io_ex.branchTaken  = io_ex.branch & ((w_opA == w_fwdB) ^ io_ex.bne);
  assign io_ex.branchTarget = io_ex.nPC + (io_ex.imm << 2);
  assign io_ex.jrTarget     = w_opA;

  always_comb begin
    w_exMemNext           = '0;
    w_exMemNext.dREN      = io_ex.dREN;
    w_exMemNext.dWEN      = io_ex.dWEN;
    w_exMemNext.regWr     = io_ex.regWr;
    w_exMemNext.ovf       = w_ovf;
    w_exMemNext.regSel    = io_ex.regSel;
    w_exMemNext.regDst    = io_ex.regDst;
    w_exMemNext.aluOut    = w_aluOut;
    w_exMemNext.storeData = w_fwdB;
    w_exMemNext.nPC       = io_ex.nPC;
  end

  // Flush beats everything; a bubble only takes effect when the pipe advances.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_exMem <= '0;
    end else if (io_ex.flush) begin
      r_exMem <= '0;
    end else if (io_ex.ihit && io_ex.bubble) begin
      r_exMem <= '0;
    end else if (io_ex.ihit) begin
      r_exMem <= w_exMemNext;
    end
  end

  assign io_ex.dREN_next      = r_exMem.dREN;
  assign io_ex.dWEN_next      = r_exMem.dWEN;
  assign io_ex.regWr_next     = r_exMem.regWr;
  assign io_ex.ovf_next       = r_exMem.ovf;
  assign io_ex.regSel_next    = r_exMem.regSel;
  assign io_ex.regDst_next    = r_exMem.regDst;
  assign io_ex.ALUOut_next    = r_exMem.aluOut;
  assign io_ex.storeData_next = r_exMem.storeData;
  assign io_ex.nPC_next       = r_exMem.nPC;

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage pipeline. It takes decoded operands and control from the decode latch, resolves forwarding from the memory and writeback stages, performs the ALU operation and branch compare, and latches results into the EX/MEM pipeline register that feeds the memory stage. Branch and jump-register resolution is combinational, for the fetch stage. All register updates are gated by ihit, bubble and flush.

## Interface
- DW, 32, datapath width
- RW, 5, register index width
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  pipeline advance enable
- flush  in  1  synchronous clear of EX/MEM register
- bubble  in  1  insert NOP into EX/MEM (load-use hazard)
- rdat1, rdat2  in  DW  register file operands
- imm  in  DW  extended immediate
- shamt  in  5  shift amount
- ALUSrc  in  1  1: operand B = imm
- ALUOp  in  4  operation code
- ovfChk  in  1  signed overflow detection enabled for this instruction
- dREN, dWEN, regWr  in  1  decoded controls
- regSel  in  2  writeback source select (0 ALU, 1 load, 2 nPC)
- regDst, rs, rt  in  RW  destination and source indices
- nPC  in  DW  PC+4 of this instruction
- branch, bne, jr  in  1  branch/jump-register controls
- mem_regWr  in  1, mem_regDst  in  RW, mem_ALUOut  in  DW  memory-stage forward source
- wb_regWr  in  1, wb_regDst  in  RW, wb_wdat  in  DW  writeback-stage forward source
- dREN_next, dWEN_next, regWr_next, ovf_next  out  1  latched
- regSel_next  out  2, regDst_next  out  RW  latched
- ALUOut_next, storeData_next, nPC_next  out  DW  latched
- branchTaken  out  1, branchTarget  out  DW, jrTarget  out  DW  combinational

## Operation
- Forwarding, operand A: if mem_regWr, mem_regDst≠0 and mem_regDst==rs, use mem_ALUOut; else if wb_regWr, wb_regDst≠0 and wb_regDst==rs, use wb_wdat; else use rdat1. Operand B uses the same rule with rt/rdat2. The memory stage has priority over writeback.
- Operand B for the ALU is imm if ALUSrc is set, else forwarded B. storeData is always forwarded B.
- ALUOp: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL B by shamt, 9 SRL, A SRA, B LUI ({imm[15:0],16'h0}). C–F produce 0.
- All arithmetic is modulo 2^DW. Overflow is set only for ADD/SUB with ovfChk=1, when the operand signs produce a wrong-signed result.
- branchTaken = branch & ((A==B) ^ bne), on forwarded A/B. branchTarget = nPC + (imm<<2). jrTarget = forwarded A. All three are unregistered and reflect current inputs.
- EX/MEM register update, priority order:
  1. nRST low: all latched outputs 0.
  2. flush: all latched outputs 0 at the edge, regardless of ihit.
  3. ihit & bubble: all latched outputs 0 (NOP).
  4. ihit: latch ALU result, controls, storeData, nPC, ovf.
  5. Otherwise: hold.

## Timing
- Latched outputs appear one cycle after the ihit edge that captures them. Forwarding and branch resolution have zero-cycle latency.
- Reset values: every latched output is 0. Combinational outputs follow inputs during reset.
- Asserting nRST mid-operation clears the register immediately (asynchronous). The first capture is on the first ihit edge after release.
- flush together with ihit: the flush wins and the instruction is dropped.
- bubble without ihit: the register holds; no NOP is inserted.
- rs==rt with both forwarding paths matching: both operands take the memory-stage value.
- Destination register 0 is never forwarded.

## Test plan
- Reset: nRST low with ihit=1, ALUOp=ADD → all *_next are 0. After release, rdat1=5, rdat2=7, ihit → ALUOut_next=12 one cycle later.
- Forwarding priority: rs=3, mem_regDst=3 (mem_ALUOut=0xAA), wb_regDst=3 (wb_wdat=0xBB), ALUOp=OR, rdat2=0 → ALUOut_next=0xAA. With mem_regWr=0 → 0xBB. With regDst=0 on both paths → rdat1.
- Overflow and signed compare: ADD 0x7FFFFFFF+1 with ovfChk=1 → ALUOut=0x80000000, ovf_next=1; same with ovfChk=0 → ovf_next=0. SLT 0xFFFFFFFF,1 → 1; SLTU → 0.
- Branch: branch=1, bne=0, A==B, nPC=0x100, imm=0xFFFFFFFF → branchTaken=1, branchTarget=0xFC. With bne=1 → branchTaken=0.
- Hold/flush/bubble: ihit=0 for 3 cycles → outputs stable. flush with ihit → all 0. bubble with ihit, dWEN=1 → dWEN_next=0, regWr_next=0.
- Shifts/LUI: rdat2=0x80000000, shamt=4 → SRA 0xF8000000, SRL 0x08000000. LUI imm=0x1234 → 0x12340000.
